// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the multiword add/sub sequencer
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LIMB_W = 16;

  // Limb index needs at least one bit even when there is a single limb.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/RippleCarryAdder16Bit.sv
// rtl/RippleCarryAdder16Bit.sv - 16-bit adder with carry in/out, shared across limbs
module RippleCarryAdder16Bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {16'd0, cin};
  assign sum   = total[15:0];
  assign cout  = total[16];

endmodule

// File: rtl/multiword_addsub_sequencer.sv
// rtl/multiword_addsub_sequencer.sv - WORDS x 16-bit add/sub, one limb per cycle on a shared adder
module multiword_addsub_sequencer
  import addsub_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LIMB_W*WORDS-1:0]   a,
  input  logic [LIMB_W*WORDS-1:0]   b,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LIMB_W*WORDS-1:0]   result,
  output logic                      carry_out,
  output logic                      signed_overflow,
  output logic                      unsigned_overflow,
  output logic                      zero_flag,
  output logic                      negative_flag,
  output logic                      busy
);

  localparam int W  = LIMB_W * WORDS;
  localparam int IW = idx_width(WORDS);

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, b_q;
  logic              sub_q;
  logic [IW-1:0]     idx_q;
  logic              carry_q;
  logic              zacc_q;

  logic [LIMB_W-1:0] a_limb, b_limb, b_eff, sum;
  logic              cout;
  logic              accept;
  logic              last_limb;

  assign a_limb    = a_q[LIMB_W*int'(idx_q) +: LIMB_W];
  assign b_limb    = b_q[LIMB_W*int'(idx_q) +: LIMB_W];
  assign b_eff     = sub_q ? ~b_limb : b_limb;
  assign last_limb = (idx_q == IW'(WORDS - 1));
  assign accept    = in_valid && (state_q == IDLE);

  RippleCarryAdder16Bit u_adder (
    .a    (a_limb),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_limb) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: busy      = 1'b1;
    endcase
  end

  // Carry starts at sub so that A + ~B + 1 forms the two's-complement difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q               <= '0;
      b_q               <= '0;
      sub_q             <= 1'b0;
      idx_q             <= '0;
      carry_q           <= 1'b0;
      zacc_q            <= 1'b0;
      result            <= '0;
      carry_out         <= 1'b0;
      signed_overflow   <= 1'b0;
      unsigned_overflow <= 1'b0;
      zero_flag         <= 1'b0;
      negative_flag     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub;
      idx_q   <= '0;
      carry_q <= sub;
      zacc_q  <= 1'b1;
    end else if (state_q == RUN) begin
      result[LIMB_W*int'(idx_q) +: LIMB_W] <= sum;
      carry_q <= cout;
      zacc_q  <= zacc_q & (sum == '0);
      idx_q   <= idx_q + IW'(1);
      if (last_limb) begin
        carry_out         <= cout;
        unsigned_overflow <= sub_q ? ~cout : cout;
        signed_overflow   <= (a_limb[LIMB_W-1] == b_eff[LIMB_W-1]) &&
                             (a_limb[LIMB_W-1] != sum[LIMB_W-1]);
        zero_flag         <= zacc_q & (sum == '0);
        negative_flag     <= sum[LIMB_W-1];
      end
    end
  end

endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// tb/tb_multiword_addsub_sequencer.sv - scoreboard bench for multiword_addsub_sequencer (WORDS=4)
module tb_multiword_addsub_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, sub;
  logic [W-1:0] a, b, result;
  logic         out_valid, out_ready;
  logic         carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag, busy;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         sov;
    logic         uov;
    logic         z;
    logic         n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  multiword_addsub_sequencer #(.WORDS(WORDS)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .a                 (a),
    .b                 (b),
    .sub               (sub),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .result            (result),
    .carry_out         (carry_out),
    .signed_overflow   (signed_overflow),
    .unsigned_overflow (unsigned_overflow),
    .zero_flag         (zero_flag),
    .negative_flag     (negative_flag),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, "_result"}, result, e.r);
    chk({tag, "_carry"}, W'(carry_out), W'(e.c));
    chk({tag, "_sov"}, W'(signed_overflow), W'(e.sov));
    chk({tag, "_uov"}, W'(unsigned_overflow), W'(e.uov));
    chk({tag, "_zero"}, W'(zero_flag), W'(e.z));
    chk({tag, "_neg"}, W'(negative_flag), W'(e.n));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", W'(1), W'(0));
        end else begin
          e = q.pop_front();
          chk_outputs("out", e);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                      output int waited);
    logic ok;
    ok       = 1'b0;
    waited   = 0;
    a        = av;
    b        = bv;
    sub      = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    in_valid = 1'b0;
    // scramble inputs to prove operands were captured
    a   = '1;
    b   = 64'h5A5A_A5A5_1234_4321;
    sub = ~s;
    if (!ok) chk("accept_timeout", W'(0), W'(1));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    if (!out_valid) chk("out_valid_timeout", W'(0), W'(1));
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s, input exp_t e);
    int waited, lat;
    q.push_back(e);
    send(av, bv, s, waited);
    wait_out(lat);
    chk("latency", W'(lat), W'(WORDS));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t bp_e, nx_e;
    int   waited, lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk_outputs("rst", '{r: '0, c: 0, sov: 0, uov: 0, z: 0, n: 0});
    rst = 1'b0;

    op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
       '{r: 64'h0000_0000_0001_0000, c: 0, sov: 0, uov: 0, z: 0, n: 0});
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
       '{r: 64'h0, c: 1, sov: 0, uov: 1, z: 1, n: 0});
    op(64'h0, 64'h1, 1'b1,
       '{r: 64'hFFFF_FFFF_FFFF_FFFF, c: 0, sov: 0, uov: 1, z: 0, n: 1});
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
       '{r: 64'h8000_0000_0000_0000, c: 0, sov: 1, uov: 0, z: 0, n: 1});
    op(64'h5, 64'h3, 1'b1,
       '{r: 64'h2, c: 1, sov: 0, uov: 0, z: 0, n: 0});
    op(64'h8000_0000_0000_0000, 64'h1, 1'b1,
       '{r: 64'h7FFF_FFFF_FFFF_FFFF, c: 1, sov: 1, uov: 0, z: 0, n: 0});

    // backpressure: hold DONE while offering operands that must be ignored
    out_ready = 1'b0;
    bp_e = '{r: 64'h2345_6789_ABCD_F001, c: 0, sov: 0, uov: 0, z: 0, n: 0};
    q.push_back(bp_e);
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, waited);
    wait_out(lat);
    chk("bp_latency", W'(lat), W'(WORDS));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = '1;
      b        = '1;
      sub      = 1'(i);
      @(negedge clk);
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk_outputs("bp_hold", bp_e);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nx_e = '{r: 64'h0000_0000_0000_FFFE, c: 1, sov: 0, uov: 0, z: 0, n: 0};
    q.push_back(nx_e);
    send(64'h0000_0000_0001_0000, 64'h2, 1'b1, waited);
    chk("bp_accept_edges", W'(waited), W'(2));
    wait_out(lat);
    chk("bp_next_latency", W'(lat), W'(WORDS));
    @(posedge clk);
    #1;

    // reset after two limbs of RUN discards the operation
    send(64'h1, 64'h1, 1'b0, waited);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk_outputs("mid_rst", '{r: '0, c: 0, sov: 0, uov: 0, z: 0, n: 0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_out_after_rst", W'(out_valid), W'(0));
    end
    @(posedge clk);
    #1;
    op(64'h0000_0000_0001_0000, 64'h1, 1'b1,
       '{r: 64'h0000_0000_0000_FFFF, c: 1, sov: 0, uov: 0, z: 0, n: 0});

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", W'(q.size()), W'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
